// File: rtl/cve2_pkg.sv
// Shared types for the branch resolution back end.
// Prediction bundle and resolver FSM states.
package cve2_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } branch_pred_t;

    typedef enum logic {
        BR_RES_IDLE,
        BR_RES_REDIRECT
    } br_res_state_e;

endpackage

// File: rtl/cve2_branch_pred_fifo.sv
// In-order queue of outstanding fetch-side predictions.
// Clear wins over push and pop in the same cycle.
module cve2_branch_pred_fifo
    import cve2_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  branch_pred_t wdata_i,
    output branch_pred_t rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [AW:0] CntMax = Depth[AW:0];
    localparam logic [AW:0] CntOne = 1;
    localparam logic [AW-1:0] PtrOne = 1;

    branch_pred_t    r_mem [Depth];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_cnt;
    logic            w_push;
    logic            w_pop;

    assign full_o  = (r_cnt == CntMax);
    assign empty_o = (r_cnt == '0);
    assign rdata_o = r_mem[r_rptr];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PtrOne;
            if (w_pop)  r_rptr <= r_rptr + PtrOne;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CntOne;
                2'b01:   r_cnt <= r_cnt - CntOne;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !clear_i) r_mem[r_wptr] <= wdata_i;
    end

endmodule

// File: rtl/cve2_branch_resolve.sv
// Compares execute outcomes with queued predictions and
// requests a fetch redirect on mispredict until acknowledged.
module cve2_branch_resolve
    import cve2_pkg::*;
#(
    parameter int Depth    = 2,
    parameter int CntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pred_valid_i,
    output logic                pred_ready_o,
    input  logic [31:0]         pred_pc_i,
    input  logic                pred_taken_i,
    input  logic [31:0]         pred_target_i,
    input  logic                res_valid_i,
    input  logic [31:0]         res_pc_i,
    input  logic                res_taken_i,
    input  logic [31:0]         res_target_i,
    input  logic                res_compressed_i,
    input  logic                flush_i,
    output logic                redirect_o,
    output logic [31:0]         redirect_pc_o,
    input  logic                redirect_ack_i,
    output logic                error_o,
    output logic [CntWidth-1:0] cnt_branch_o,
    output logic [CntWidth-1:0] cnt_mispred_o
);

    localparam logic [CntWidth-1:0] CntOne = 1;

    br_res_state_e       r_state;
    logic                r_redirect;
    logic [31:0]         r_redirect_pc;
    logic                r_error;
    logic [CntWidth-1:0] r_cnt_branch;
    logic [CntWidth-1:0] r_cnt_mispred;

    branch_pred_t w_head;
    branch_pred_t w_wdata;
    logic         w_full;
    logic         w_empty;
    logic         w_idle;
    logic         w_res;
    logic         w_match;
    logic         w_mis;
    logic         w_err;
    logic         w_push;
    logic         w_pop;
    logic         w_clear;
    logic [31:0]  w_seq_pc;
    logic [31:0]  w_corr_pc;

    assign w_idle       = (r_state == BR_RES_IDLE);
    assign pred_ready_o = w_idle && !w_full;

    assign w_res   = w_idle && res_valid_i && !flush_i;
    assign w_match = !w_empty && (w_head.pc == res_pc_i);
    assign w_err   = w_res && !w_match;
    assign w_pop   = w_res && !w_empty;
    assign w_mis   = w_res && w_match &&
                     ((w_head.taken != res_taken_i) ||
                      (res_taken_i && (w_head.target != res_target_i)));

    // A mispredict clears the queue, which also drops any same-cycle push.
    assign w_clear = flush_i || w_mis;
    assign w_push  = pred_valid_i && pred_ready_o && !w_clear;

    assign w_seq_pc  = res_pc_i + (res_compressed_i ? 32'd2 : 32'd4);
    assign w_corr_pc = res_taken_i ? res_target_i : w_seq_pc;

    assign w_wdata.pc     = pred_pc_i;
    assign w_wdata.taken  = pred_taken_i;
    assign w_wdata.target = pred_target_i;

    cve2_branch_pred_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .clear_i (w_clear),
        .wdata_i (w_wdata),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= BR_RES_IDLE;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_error       <= 1'b0;
            r_cnt_branch  <= '0;
            r_cnt_mispred <= '0;
        end else begin
            r_error <= w_err;
            if (w_res && w_match && (r_cnt_branch != '1))
                r_cnt_branch <= r_cnt_branch + CntOne;
            if (w_mis && (r_cnt_mispred != '1))
                r_cnt_mispred <= r_cnt_mispred + CntOne;
            if (flush_i) begin
                r_state    <= BR_RES_IDLE;
                r_redirect <= 1'b0;
            end else begin
                case (r_state)
                    BR_RES_IDLE: begin
                        if (w_mis) begin
                            r_state       <= BR_RES_REDIRECT;
                            r_redirect    <= 1'b1;
                            r_redirect_pc <= w_corr_pc;
                        end
                    end
                    BR_RES_REDIRECT: begin
                        if (redirect_ack_i) begin
                            r_state    <= BR_RES_IDLE;
                            r_redirect <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= BR_RES_IDLE;
                        r_redirect <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign error_o       = r_error;
    assign cnt_branch_o  = r_cnt_branch;
    assign cnt_mispred_o = r_cnt_mispred;

endmodule

// File: doc/cve2_branch_resolve.md
Name: cve2_branch_resolve

Overview:
Back end of static branch prediction. Fetch-side predictions (PC, taken flag, target) are queued in order. When execute reports the real outcome of each branch or jump, the block compares it with the queued prediction. On a mismatch it raises a registered redirect/flush request, holds it until the fetch stage acknowledges, and keeps branch and misprediction performance counters.

Parameters:
Depth, 2, number of outstanding predictions tracked; power of two, at least 2.
CntWidth, 32, width of each saturating performance counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
pred_valid_i  in  1  a predicted branch/jump leaves fetch
pred_ready_o  out  1  block can accept a prediction
pred_pc_i  in  32  PC of the predicted instruction
pred_taken_i  in  1  predicted direction
pred_target_i  in  32  predicted target (valid only when taken)
res_valid_i  in  1  execute resolves the oldest branch/jump
res_pc_i  in  32  PC of the resolved instruction
res_taken_i  in  1  actual direction
res_target_i  in  32  actual target
res_compressed_i  in  1  resolved instruction is 16-bit
flush_i  in  1  pipeline flush from controller (exception, debug, fence)
redirect_o  out  1  misprediction recovery request
redirect_pc_o  out  32  correct fetch PC
redirect_ack_i  in  1  fetch has taken the redirect
error_o  out  1  one-cycle pulse on an illegal resolution
cnt_branch_o  out  CntWidth  number of resolved branches/jumps
cnt_mispred_o  out  CntWidth  number of mispredictions

Behaviour:
- Reset values: all outputs 0 except pred_ready_o=1. FIFO empty; state IDLE.
- FIFO: Depth entries of {pc, taken, target}; read and write pointers wrap modulo Depth; an explicit count distinguishes full from empty.
- Push: happens when pred_valid_i && pred_ready_o.
  - pred_ready_o = (state==IDLE) && !full.
  - In the same cycle as a pop while full, pred_ready_o stays 0; no combinational path from res_* to ready.
- Resolve is evaluated only in IDLE with res_valid_i=1:
  - FIFO empty: error_o=1 next cycle; nothing popped; counters unchanged.
  - Head pc != res_pc_i: head popped; error_o=1; no redirect; counters unchanged.
  - Head pc matches: pop head; cnt_branch++.
    - Mispredict = (taken != res_taken_i) || (res_taken_i && target != res_target_i).
    - Correct PC = res_taken_i ? res_target_i : res_pc_i + (res_compressed_i ? 2 : 4), computed modulo 2^32.
- Counters saturate at all-ones and never wrap.
- FSM:
  - IDLE -> REDIRECT on mispredict. In that same edge: FIFO cleared (younger entries are wrong-path), any same-cycle push discarded, cnt_mispred++, redirect_pc_o latched.
  - REDIRECT: redirect_o=1 and redirect_pc_o stable. pred_ready_o=0. res_valid_i ignored.
  - REDIRECT -> IDLE on redirect_ack_i; redirect_o drops the following cycle. An ack arriving in the first REDIRECT cycle is honoured.
- Latency: redirect_o rises exactly 1 cycle after the mispredicting resolution; error_o likewise.
- flush_i has highest priority:
  - Clears the FIFO, forces IDLE, drops redirect_o next cycle.
  - Discards same-cycle push and resolve.
  - Counters are not updated by a resolve discarded this way.
- Async reset mid-REDIRECT: redirect_o returns to 0 immediately, FIFO empties, counters return to 0.

Decomposition:
- Add to cve2_pkg:
  - typedef branch_pred_t {logic [31:0] pc; logic taken; logic [31:0] target;}
  - typedef enum {BR_RES_IDLE, BR_RES_REDIRECT} br_res_state_e
- Sub-module cve2_branch_pred_fifo: generic Depth FIFO of branch_pred_t with push, pop, clear, full and empty.
- FSM, comparison and counters stay in the top module.

Test Plan:
- Push {pc=0x100, taken=1, target=0xF0}; resolve pc=0x100, taken=1, target=0xF0 -> no redirect, cnt_branch=1, cnt_mispred=0.
- Push {0x200, taken=0}; resolve taken=1, target=0x180 -> redirect_o next cycle with pc=0x180, held 3 cycles until ack, then 0; cnt_mispred=1.
- Push {0x300, taken=1, target=0x2F0}; resolve taken=0, res_compressed_i=1 -> redirect_pc_o=0x302. Repeat with res_compressed_i=0 -> 0x304. Repeat with pc=0xFFFFFFFC, 32-bit -> 0x00000000.
- Fill with 2 entries -> pred_ready_o=0. Mispredict on head -> FIFO emptied and second entry discarded; a later resolve gives error_o pulse.
- Resolve with FIFO empty -> error_o=1 for one cycle, counters unchanged. Resolve pc=0x404 against head 0x400 -> error_o, head popped, no redirect.
- flush_i asserted during REDIRECT with a pending push -> redirect_o=0 next cycle, FIFO empty, pred_ready_o=1. Preset counters to all-ones -> they stay saturated after further resolves.
